// File: rtl/axi_bresp_router_1_2.sv
// axi_bresp_router_1_2
// Write-response return path for a 2-master interconnect. An in-order queue
// of master indices (pushed per accepted AW, popped per accepted B) steers the
// single slave B channel to the master that issued the write. A one-entry
// hold register per response keeps it stable until the destination accepts.
module axi_bresp_router_1_2 #(
    parameter int ORDER_DEPTH = 4,
    parameter int PTR_W       = $clog2(ORDER_DEPTH)
) (
    input  logic       ACLK,
    input  logic       ARESETN,
    input  logic       AW_push,
    input  logic       AW_master,
    output logic       order_full,
    input  logic [1:0] M_AXI_bresp,
    input  logic       M_AXI_bvalid,
    output logic       M_AXI_bready,
    output logic [1:0] S00_AXI_bresp,
    output logic       S00_AXI_bvalid,
    input  logic       S00_AXI_bready,
    output logic [1:0] S01_AXI_bresp,
    output logic       S01_AXI_bvalid,
    input  logic       S01_AXI_bready,
    output logic       resp_error
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(ORDER_DEPTH);

    // Order queue storage and bookkeeping
    logic               r_order [ORDER_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;

    // Output hold stage
    logic               r_hold_valid;
    logic               r_hold_dest;
    logic [1:0]         r_hold_resp;
    logic               r_resp_error;

    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic               w_head;
    logic               w_dest_bready;
    logic               w_release;
    logic               w_bready_out;
    logic [1:0]         w_bready;
    logic [1:0]         w_bvalid;

    assign w_full        = (r_count == FULL_CNT);
    assign w_push        = AW_push && !w_full;
    assign w_head        = r_order[r_rd_ptr];
    assign w_bready      = {S01_AXI_bready, S00_AXI_bready};
    assign w_dest_bready = w_bready[r_hold_dest];
    assign w_release     = r_hold_valid && w_dest_bready;
    // Accept a new response only when an entry is queued and the hold slot
    // is empty or being released on this same edge (back-to-back capture).
    assign w_bready_out  = (r_count != '0) && (!r_hold_valid || w_dest_bready);
    assign w_pop         = M_AXI_bvalid && w_bready_out;

    // Per-master valid decode: only the held destination sees bvalid.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dest
            assign w_bvalid[gi] = r_hold_valid && (r_hold_dest == 1'(gi));
        end
    endgenerate

    assign order_full     = w_full;
    assign M_AXI_bready   = w_bready_out;
    assign S00_AXI_bvalid = w_bvalid[0];
    assign S01_AXI_bvalid = w_bvalid[1];
    assign S00_AXI_bresp  = r_hold_resp;
    assign S01_AXI_bresp  = r_hold_resp;
    assign resp_error     = r_resp_error;

    // Queue payload write; contents are don't-care when count says empty.
    always_ff @(posedge ACLK) begin
        if (w_push) begin
            r_order[r_wr_ptr] <= AW_master;
        end
    end

    // Queue pointers and occupancy count; pointers wrap naturally.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Hold register: capture on slave handshake, otherwise clear on release.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_hold_valid <= 1'b0;
            r_hold_dest  <= 1'b0;
            r_hold_resp  <= 2'b00;
        end else if (w_pop) begin
            r_hold_valid <= 1'b1;
            r_hold_dest  <= w_head;
            r_hold_resp  <= M_AXI_bresp;
        end else if (w_release) begin
            r_hold_valid <= 1'b0;
        end
    end

    // Sticky error: response with nothing outstanding, or AW dropped when full.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_resp_error <= 1'b0;
        end else if ((M_AXI_bvalid && (r_count == '0)) || (AW_push && w_full)) begin
            r_resp_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_bresp_router_1_2.sv
// Directed testbench for axi_bresp_router_1_2: linear stimulus, immediate
// assertions with hand-computed expectations.
module tb_axi_bresp_router_1_2;

    logic       ACLK = 1'b0;
    logic       ARESETN;
    logic       AW_push;
    logic       AW_master;
    logic       order_full;
    logic [1:0] M_AXI_bresp;
    logic       M_AXI_bvalid;
    logic       M_AXI_bready;
    logic [1:0] S00_AXI_bresp;
    logic       S00_AXI_bvalid;
    logic       S00_AXI_bready;
    logic [1:0] S01_AXI_bresp;
    logic       S01_AXI_bvalid;
    logic       S01_AXI_bready;
    logic       resp_error;

    int tests = 0;
    int fails = 0;

    axi_bresp_router_1_2 #(.ORDER_DEPTH(4)) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .AW_push       (AW_push),
        .AW_master     (AW_master),
        .order_full    (order_full),
        .M_AXI_bresp   (M_AXI_bresp),
        .M_AXI_bvalid  (M_AXI_bvalid),
        .M_AXI_bready  (M_AXI_bready),
        .S00_AXI_bresp (S00_AXI_bresp),
        .S00_AXI_bvalid(S00_AXI_bvalid),
        .S00_AXI_bready(S00_AXI_bready),
        .S01_AXI_bresp (S01_AXI_bresp),
        .S01_AXI_bvalid(S01_AXI_bvalid),
        .S01_AXI_bready(S01_AXI_bready),
        .resp_error    (resp_error)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("[TB] %s observed %0h expected %0h", tag, obs, exp);
    endtask

    // Move to 1 ns after the next rising edge.
    task automatic cyc();
        @(posedge ACLK);
        #1;
    endtask

    // Settle combinational outputs after driving inputs.
    task automatic settle();
        #1;
    endtask

    initial begin
        ARESETN        = 1'b0;
        AW_push        = 1'b0;
        AW_master      = 1'b0;
        M_AXI_bresp    = 2'b00;
        M_AXI_bvalid   = 1'b0;
        S00_AXI_bready = 1'b1;
        S01_AXI_bready = 1'b1;
        #3;
        chk("rst_s00_bvalid", {3'b0, S00_AXI_bvalid}, 4'h0);
        chk("rst_s01_bvalid", {3'b0, S01_AXI_bvalid}, 4'h0);
        chk("rst_m_bready",   {3'b0, M_AXI_bready},   4'h0);
        chk("rst_full",       {3'b0, order_full},     4'h0);
        chk("rst_err",        {3'b0, resp_error},     4'h0);
        chk("rst_bresp",      {S01_AXI_bresp, S00_AXI_bresp}, 4'h0);
        cyc(); cyc();
        ARESETN = 1'b1;
        cyc();

        // ---- Single write to master 1 ----
        AW_push = 1'b1; AW_master = 1'b1; settle();
        chk("t1_no_bypass", {3'b0, M_AXI_bready}, 4'h0);
        cyc();
        AW_push = 1'b0; settle();
        chk("t1_bready_after_push", {3'b0, M_AXI_bready}, 4'h1);
        cyc();
        M_AXI_bvalid = 1'b1; M_AXI_bresp = 2'b10; settle();
        chk("t1_bready_hs", {3'b0, M_AXI_bready}, 4'h1);
        cyc();
        M_AXI_bvalid = 1'b0; settle();
        chk("t1_s01_bvalid", {3'b0, S01_AXI_bvalid}, 4'h1);
        chk("t1_s01_bresp",  {2'b0, S01_AXI_bresp},  4'h2);
        chk("t1_s00_bvalid", {3'b0, S00_AXI_bvalid}, 4'h0);
        chk("t1_count0_bready", {3'b0, M_AXI_bready}, 4'h0);
        cyc();
        chk("t1_released", {3'b0, S01_AXI_bvalid}, 4'h0);

        // ---- Ordering: masters 0,1,1,0 ----
        AW_push = 1'b1; AW_master = 1'b0; cyc();
        AW_master = 1'b1; cyc();
        AW_master = 1'b1; cyc();
        AW_master = 1'b0; settle();
        chk("t2_not_full_at3", {3'b0, order_full}, 4'h0);
        cyc();
        AW_push = 1'b0; settle();
        chk("t2_full_at4", {3'b0, order_full}, 4'h1);
        M_AXI_bvalid = 1'b1; M_AXI_bresp = 2'b00; settle();
        chk("t2_bready0", {3'b0, M_AXI_bready}, 4'h1);
        cyc();
        M_AXI_bresp = 2'b10; settle();
        chk("t2_r0_s00v", {3'b0, S00_AXI_bvalid}, 4'h1);
        chk("t2_r0_s00r", {2'b0, S00_AXI_bresp},  4'h0);
        chk("t2_r0_s01v", {3'b0, S01_AXI_bvalid}, 4'h0);
        chk("t2_bready1", {3'b0, M_AXI_bready},   4'h1);
        cyc();
        M_AXI_bresp = 2'b11; settle();
        chk("t2_r1_s01v", {3'b0, S01_AXI_bvalid}, 4'h1);
        chk("t2_r1_s01r", {2'b0, S01_AXI_bresp},  4'h2);
        chk("t2_r1_s00v", {3'b0, S00_AXI_bvalid}, 4'h0);
        cyc();
        M_AXI_bresp = 2'b01; settle();
        chk("t2_r2_s01v", {3'b0, S01_AXI_bvalid}, 4'h1);
        chk("t2_r2_s01r", {2'b0, S01_AXI_bresp},  4'h3);
        cyc();
        M_AXI_bvalid = 1'b0; settle();
        chk("t2_r3_s00v", {3'b0, S00_AXI_bvalid}, 4'h1);
        chk("t2_r3_s00r", {2'b0, S00_AXI_bresp},  4'h1);
        chk("t2_r3_s01v", {3'b0, S01_AXI_bvalid}, 4'h0);
        chk("t2_empty_bready", {3'b0, M_AXI_bready}, 4'h0);
        chk("t2_no_err", {3'b0, resp_error}, 4'h0);
        cyc();
        chk("t2_released", {3'b0, S00_AXI_bvalid}, 4'h0);

        // ---- Full / wrap: queue 1,0,1,0 ; drop ; then 0,1 with pops ----
        AW_push = 1'b1; AW_master = 1'b1; cyc();
        AW_master = 1'b0; cyc();
        AW_master = 1'b1; cyc();
        AW_master = 1'b0; cyc();
        AW_master = 1'b0; settle();
        chk("t3_full", {3'b0, order_full}, 4'h1);
        chk("t3_err_before", {3'b0, resp_error}, 4'h0);
        chk("t3_bready_full", {3'b0, M_AXI_bready}, 4'h1);
        cyc();
        AW_push = 1'b0; M_AXI_bvalid = 1'b1; M_AXI_bresp = 2'b01; settle();
        chk("t3_err_set", {3'b0, resp_error}, 4'h1);
        chk("t3_still_full", {3'b0, order_full}, 4'h1);
        cyc();
        AW_push = 1'b1; AW_master = 1'b0; M_AXI_bresp = 2'b10; settle();
        chk("t3_p0_s01v", {3'b0, S01_AXI_bvalid}, 4'h1);
        chk("t3_p0_s01r", {2'b0, S01_AXI_bresp},  4'h1);
        chk("t3_not_full", {3'b0, order_full}, 4'h0);
        chk("t3_bready_b2b", {3'b0, M_AXI_bready}, 4'h1);
        cyc();
        AW_master = 1'b1; M_AXI_bresp = 2'b11; settle();
        chk("t3_p1_s00v", {3'b0, S00_AXI_bvalid}, 4'h1);
        chk("t3_p1_s00r", {2'b0, S00_AXI_bresp},  4'h2);
        chk("t3_p1_s01v", {3'b0, S01_AXI_bvalid}, 4'h0);
        cyc();
        AW_push = 1'b0; M_AXI_bresp = 2'b00; settle();
        chk("t3_p2_s01v", {3'b0, S01_AXI_bvalid}, 4'h1);
        chk("t3_p2_s01r", {2'b0, S01_AXI_bresp},  4'h3);
        cyc();
        M_AXI_bresp = 2'b01; settle();
        chk("t3_p3_s00v", {3'b0, S00_AXI_bvalid}, 4'h1);
        chk("t3_p3_s00r", {2'b0, S00_AXI_bresp},  4'h0);
        cyc();
        M_AXI_bresp = 2'b10; settle();
        chk("t3_p4_s00v", {3'b0, S00_AXI_bvalid}, 4'h1);
        chk("t3_p4_s00r", {2'b0, S00_AXI_bresp},  4'h1);
        chk("t3_p4_s01v", {3'b0, S01_AXI_bvalid}, 4'h0);
        cyc();
        M_AXI_bvalid = 1'b0; settle();
        chk("t3_p5_s01v", {3'b0, S01_AXI_bvalid}, 4'h1);
        chk("t3_p5_s01r", {2'b0, S01_AXI_bresp},  4'h2);
        chk("t3_p5_s00v", {3'b0, S00_AXI_bvalid}, 4'h0);
        chk("t3_empty_bready", {3'b0, M_AXI_bready}, 4'h0);
        chk("t3_err_sticky", {3'b0, resp_error}, 4'h1);
        cyc();

        // ---- Backpressure on master 0 ----
        S00_AXI_bready = 1'b0;
        AW_push = 1'b1; AW_master = 1'b0; cyc();
        M_AXI_bvalid = 1'b1; M_AXI_bresp = 2'b10; cyc();
        AW_push = 1'b0; M_AXI_bresp = 2'b11;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("t4_hold_s00v", {3'b0, S00_AXI_bvalid}, 4'h1);
            chk("t4_hold_s00r", {2'b0, S00_AXI_bresp},  4'h2);
            chk("t4_hold_bready", {3'b0, M_AXI_bready}, 4'h0);
            chk("t4_hold_s01v", {3'b0, S01_AXI_bvalid}, 4'h0);
            cyc();
        end
        S00_AXI_bready = 1'b1; settle();
        chk("t4_rel_s00r", {2'b0, S00_AXI_bresp}, 4'h2);
        chk("t4_rel_bready", {3'b0, M_AXI_bready}, 4'h1);
        cyc();
        M_AXI_bvalid = 1'b0; settle();
        chk("t4_b2b_s00v", {3'b0, S00_AXI_bvalid}, 4'h1);
        chk("t4_b2b_s00r", {2'b0, S00_AXI_bresp},  4'h3);
        chk("t4_b2b_bready", {3'b0, M_AXI_bready}, 4'h0);
        cyc();
        chk("t4_done_s00v", {3'b0, S00_AXI_bvalid}, 4'h0);

        // ---- Reset to clear the sticky error, then spurious response ----
        ARESETN = 1'b0; settle();
        chk("t5_rst_err", {3'b0, resp_error}, 4'h0);
        cyc();
        ARESETN = 1'b1; cyc();
        M_AXI_bvalid = 1'b1; M_AXI_bresp = 2'b11; settle();
        chk("t5_spur_bready", {3'b0, M_AXI_bready}, 4'h0);
        chk("t5_err_pre", {3'b0, resp_error}, 4'h0);
        cyc();
        M_AXI_bvalid = 1'b0; settle();
        chk("t5_err_set", {3'b0, resp_error}, 4'h1);
        chk("t5_s00v", {3'b0, S00_AXI_bvalid}, 4'h0);
        chk("t5_s01v", {3'b0, S01_AXI_bvalid}, 4'h0);
        cyc(); cyc();
        chk("t5_err_sticky", {3'b0, resp_error}, 4'h1);

        // ---- Reset mid-operation: one held for S01, two queued ----
        S01_AXI_bready = 1'b0;
        AW_push = 1'b1; AW_master = 1'b1; cyc();
        AW_master = 1'b0; M_AXI_bvalid = 1'b1; M_AXI_bresp = 2'b10; cyc();
        AW_master = 1'b1; M_AXI_bvalid = 1'b0; cyc();
        AW_push = 1'b0; settle();
        chk("t6_held_s01v", {3'b0, S01_AXI_bvalid}, 4'h1);
        chk("t6_held_bready", {3'b0, M_AXI_bready}, 4'h0);
        ARESETN = 1'b0; settle();
        chk("t6_rst_s01v", {3'b0, S01_AXI_bvalid}, 4'h0);
        chk("t6_rst_s00v", {3'b0, S00_AXI_bvalid}, 4'h0);
        chk("t6_rst_bready", {3'b0, M_AXI_bready}, 4'h0);
        chk("t6_rst_full", {3'b0, order_full}, 4'h0);
        chk("t6_rst_err", {3'b0, resp_error}, 4'h0);
        chk("t6_rst_bresp", {S01_AXI_bresp, S00_AXI_bresp}, 4'h0);
        cyc();
        ARESETN = 1'b1; S01_AXI_bready = 1'b1; cyc();
        M_AXI_bvalid = 1'b0; settle();
        chk("t6_count0_bready", {3'b0, M_AXI_bready}, 4'h0);
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
